// File: rtl/mdu_pkg.sv
// Shared definitions for the multicycle multiply/divide unit: op codes,
// FSM states and small op-classification helpers.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } mdu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for a latency window (everything below MTHI).
    function automatic logic is_multicycle(input logic [3:0] f_op);
        return (f_op <= OP_MSUBU);
    endfunction

    // Divide ops use the divide latency; the other multicycle ops use the multiply latency.
    function automatic logic is_div(input logic [3:0] f_op);
        return (f_op == OP_DIV) || (f_op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational result generator: from the latched operands/op and the
// current HI/LO, produce the next {hi,lo} and whether it should be written.
module mdu_compute
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n,
    output logic             we
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    w_prod_u;
    logic [W2-1:0]    w_prod_s;
    logic [W2-1:0]    w_acc;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_div_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_q_u;
    logic [WIDTH-1:0] w_r_u;
    logic [WIDTH-1:0] w_q_m;
    logic [WIDTH-1:0] w_r_m;

    // Products are formed at double width; sign-extending both operands makes the
    // modular double-width product equal to the signed product.
    assign w_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign w_acc    = {hi, lo};

    // A zero divisor is replaced by 1 so the dividers never see zero; the result is discarded anyway.
    assign w_b_zero = (b == '0);
    assign w_div_b  = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;

    // Signed divide via magnitudes; MIN_INT's magnitude is representable as unsigned,
    // so MIN_INT / -1 naturally wraps back to MIN_INT with a zero remainder.
    assign w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_abs_b = w_div_b[WIDTH-1] ? (~w_div_b + 1'b1) : w_div_b;
    assign w_q_u   = a / w_div_b;
    assign w_r_u   = a % w_div_b;
    assign w_q_m   = w_abs_a / w_abs_b;
    assign w_r_m   = w_abs_a % w_abs_b;

    // Select the result for the latched op; unknown ops leave HI/LO untouched.
    always_comb begin
        hi_n = hi;
        lo_n = lo;
        we   = 1'b0;
        case (op)
            OP_MULT:  begin {hi_n, lo_n} = w_prod_s;         we = 1'b1; end
            OP_MULTU: begin {hi_n, lo_n} = w_prod_u;         we = 1'b1; end
            OP_MADD:  begin {hi_n, lo_n} = w_acc + w_prod_s; we = 1'b1; end
            OP_MADDU: begin {hi_n, lo_n} = w_acc + w_prod_u; we = 1'b1; end
            OP_MSUB:  begin {hi_n, lo_n} = w_acc - w_prod_s; we = 1'b1; end
            OP_MSUBU: begin {hi_n, lo_n} = w_acc - w_prod_u; we = 1'b1; end
            OP_DIV: begin
                if (!w_b_zero) begin
                    lo_n = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~w_q_m + 1'b1) : w_q_m;
                    hi_n = a[WIDTH-1] ? (~w_r_m + 1'b1) : w_r_m;
                    we   = 1'b1;
                end
            end
            OP_DIVU: begin
                if (!w_b_zero) begin
                    lo_n = w_q_u;
                    hi_n = w_r_u;
                    we   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_multicycle.sv
// Multicycle multiply/divide unit: IDLE/BUSY FSM with a latency counter,
// operand latches and the architectural HI/LO registers.
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    mdu_state_e       r_state;
    mdu_state_e       w_state_n;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_n;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_idle;
    logic             w_accept;
    logic             w_launch;
    logic             w_last;
    logic             w_commit;
    logic [WIDTH-1:0] w_hi_n;
    logic [WIDTH-1:0] w_lo_n;
    logic             w_we;

    // Starts are only honoured while idle and never alongside a flush.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && start && !cancel;
    assign w_launch = w_accept && is_multicycle(op);
    assign w_last   = (r_state == ST_BUSY) && (r_count == CNT_W'(1));
    assign w_commit = w_last && !cancel && w_we;

    mdu_compute #(.WIDTH(WIDTH)) u_compute (
        .op   (r_op),
        .a    (r_a),
        .b    (r_b),
        .hi   (r_hi),
        .lo   (r_lo),
        .hi_n (w_hi_n),
        .lo_n (w_lo_n),
        .we   (w_we)
    );

    // State and latency counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_n;
            r_count <= w_count_n;
        end
    end

    // Next state: launch loads the op latency; count down to 1, or abort on cancel.
    always_comb begin
        w_state_n = r_state;
        w_count_n = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_n = ST_BUSY;
                    w_count_n = is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                end
            end
            ST_BUSY: begin
                if (cancel || w_last) begin
                    w_state_n = ST_IDLE;
                    w_count_n = '0;
                end else begin
                    w_count_n = r_count - CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_count_n = '0;
            end
        endcase
    end

    // Operand latches capture the launching instruction; they need no reset.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
        end
    end

    // HI/LO: multicycle results commit on the last busy cycle; MTHI/MTLO write immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_hi_n;
            r_lo <= w_lo_n;
        end else if (w_accept && (op == OP_MTHI)) begin
            r_hi <= a;
        end else if (w_accept && (op == OP_MTLO)) begin
            r_lo <= a;
        end
    end

    assign busy = (r_state == ST_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
